// File: rtl/nand_cpu_mc_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer that owns the PC and instruction register.
// Define NAND_CPU_PERF_CNT_EN to add the cycle_cnt / retired_cnt performance counters.
module nand_cpu_mc_sequencer #(
  parameter int PC_SIZE     = 8,
  parameter int INSTR_W     = 8,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  output logic               i_req,
  output logic [PC_SIZE-1:0] i_addr,
  input  logic               i_ack,
  input  logic [INSTR_W-1:0] i_rdata,
  output logic [INSTR_W-1:0] instr,
  input  logic               dec_mem_rd,
  input  logic               dec_mem_wr,
  input  logic               dec_reg_we,
  input  logic               dec_halt,
  input  logic               br_taken,
  input  logic [PC_SIZE-1:0] br_target,
  output logic               d_req,
  output logic               d_we,
  input  logic               d_ack,
  output logic               reg_we,
  output logic [PC_SIZE-1:0] pc,
  output logic               halted,
  output logic               fault
`ifdef NAND_CPU_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retired_cnt
`endif
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  state_t             state_reg;
  logic [PC_SIZE-1:0] pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [TW-1:0]      to_cnt_reg;
  logic               timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT > 0) && (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg  <= S_FETCH;
      pc_reg     <= PC_SIZE'(RESET_PC);
      instr_reg  <= '0;
      to_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (i_ack) begin
            instr_reg <= i_rdata;
            state_reg <= S_EXEC;
          end else if (timeout_hit) begin
            state_reg <= S_FAULT;
          end else if (MEM_TIMEOUT > 0) begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
          end
        end
        S_EXEC: begin
          if (dec_halt) begin
            state_reg <= S_HALT;
          end else if (dec_mem_rd || dec_mem_wr) begin
            state_reg  <= S_MEM;
            to_cnt_reg <= '0;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (d_ack) begin
            state_reg <= S_WB;
          end else if (timeout_hit) begin
            state_reg <= S_FAULT;
          end else if (MEM_TIMEOUT > 0) begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
          end
        end
        S_WB: begin
          // pc + 1 wraps naturally in PC_SIZE bits
          pc_reg     <= br_taken ? br_target : pc_reg + PC_SIZE'(1);
          to_cnt_reg <= '0;
          state_reg  <= S_FETCH;
        end
        S_HALT:  state_reg <= S_HALT;
        S_FAULT: state_reg <= S_FAULT;
        default: state_reg <= S_FAULT;
      endcase
    end
  end

  // Reset forces FETCH, so i_req alone needs masking while n_rst is low.
  assign i_req  = n_rst && (state_reg == S_FETCH);
  assign i_addr = pc_reg;
  assign pc     = pc_reg;
  assign instr  = instr_reg;
  assign d_req  = (state_reg == S_MEM);
  assign d_we   = (state_reg == S_MEM) && dec_mem_wr;
  assign reg_we = (state_reg == S_WB) && dec_reg_we;
  assign halted = (state_reg == S_HALT);
  assign fault  = (state_reg == S_FAULT);

`ifdef NAND_CPU_PERF_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (state_reg != S_HALT && state_reg != S_FAULT) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (state_reg == S_WB) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nand_cpu_mc_sequencer.sv
// Scoreboard bench: a program-level model predicts every handshake, writeback and halt/fault with cycle stamps.
// Random memory latencies; the bench also plays the decoder and branch controller from instr bits.
module tb_nand_cpu_mc_sequencer;

  localparam int PCW = 8;
  localparam int IW  = 8;
  localparam int TO  = 16;
  localparam int RPC = 0;

  logic           clk = 1'b0;
  logic           n_rst;
  logic           i_req, i_ack, d_req, d_we, d_ack, reg_we, halted, fault;
  logic [PCW-1:0] i_addr, pc, br_target;
  logic [IW-1:0]  i_rdata, instr;
  logic           dec_mem_rd, dec_mem_wr, dec_reg_we, dec_halt, br_taken;
`ifdef NAND_CPU_PERF_CNT_EN
  logic [31:0]    cycle_cnt, retired_cnt;
`endif

  always #5 clk = ~clk;

  nand_cpu_mc_sequencer #(
    .PC_SIZE(PCW), .INSTR_W(IW), .RESET_PC(RPC), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .instr(instr),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_reg_we(dec_reg_we), .dec_halt(dec_halt),
    .br_taken(br_taken), .br_target(br_target),
    .d_req(d_req), .d_we(d_we), .d_ack(d_ack),
    .reg_we(reg_we), .pc(pc), .halted(halted), .fault(fault)
`ifdef NAND_CPU_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  // Environment state: program memory, latency tables, halt point
  logic [7:0] imem [256];
  int idel [64];
  int ddel [64];
  int nfetch, ndata, iwait, dwait;
  int halt_at;
  int exp_halt_pc;

  // Decoder / branch controller stand-in
  assign dec_mem_rd = instr[0];
  assign dec_mem_wr = instr[1];
  assign dec_reg_we = instr[2];
  assign br_taken   = instr[3];
  assign br_target  = {instr[7:4], instr[7:4]};
  assign dec_halt   = (nfetch == halt_at);

  typedef struct {
    int kind;  // 0 fetch, 1 data, 2 reg_we, 3 halted, 4 fault
    int val;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input int val, input int cyc);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d expected none", kind, val, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d expected kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end else begin
        $display("ok kind=%0d val=%0d cyc=%0d", kind, val, cyc);
      end
    end
  endtask

  // Program-level reference: walks the program and stamps each event with its cycle
  task automatic run_model(input int k);
    int p, t, m, wb, e;
    logic [7:0] ins;
    p = RPC;
    t = 0;
    m = 0;
    for (int n = 1; n <= k; n++) begin
      sb.push_back('{kind: 0, val: p, cyc: t + idel[(n - 1) % 64]});
      t   = t + idel[(n - 1) % 64];   // ack cycle
      ins = imem[p];
      if (n == k) begin
        sb.push_back('{kind: 3, val: p, cyc: t + 2});
        exp_halt_pc = p;
        break;
      end
      if (ins[0] || ins[1]) begin
        e = t + 2 + ddel[m % 64];
        sb.push_back('{kind: 1, val: int'(ins[1]), cyc: e});
        m++;
        wb = e + 1;
      end else begin
        wb = t + 2;
      end
      if (ins[2]) sb.push_back('{kind: 2, val: p, cyc: wb});
      p = ins[3] ? {ins[7:4], ins[7:4]} : (p + 1) % 256;
      t = wb + 1;
    end
  endtask

  // Memory responders: drive acks shortly after the falling edge
  always @(negedge clk) begin
    #1;
    if (!n_rst) begin
      i_ack = 1'b0; d_ack = 1'b0;
      nfetch = 0; ndata = 0; iwait = 0; dwait = 0;
    end else begin
      if (i_req) begin
        if (iwait >= idel[nfetch % 64]) begin
          i_ack = 1'b1; i_rdata = imem[i_addr]; nfetch++; iwait = 0;
        end else begin
          i_ack = 1'b0; i_rdata = 8'($urandom); iwait++;
        end
      end else begin
        i_ack = 1'($urandom); i_rdata = 8'($urandom); iwait = 0;
      end
      if (d_req) begin
        if (dwait >= ddel[ndata % 64]) begin
          d_ack = 1'b1; ndata++; dwait = 0;
        end else begin
          d_ack = 1'b0; dwait++;
        end
      end else begin
        d_ack = 1'($urandom); dwait = 0;
      end
    end
  end

  // Monitor: samples just before the rising edge
  int  mcyc;
  logic prev_h, prev_f;
  always @(negedge clk) begin
    #4;
    if (!n_rst) begin
      mcyc = 0; prev_h = 1'b0; prev_f = 1'b0;
    end else begin
      chk("i_addr_eq_pc", int'(i_addr), int'(pc));
      if (i_req && i_ack) observe(0, int'(pc), mcyc);
      if (d_req && d_ack) observe(1, int'(d_we), mcyc);
      if (reg_we) observe(2, int'(pc), mcyc);
      if (halted && !prev_h) observe(3, int'(pc), mcyc);
      if (fault && !prev_f) observe(4, int'(pc), mcyc);
      prev_h = halted;
      prev_f = fault;
      mcyc++;
    end
  end

  task automatic hold_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();
  endtask

  task automatic release_reset();
    #1 n_rst = 1'b1;
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d pending events expected 0", name, sb.size());
    end
  endtask

  task automatic check_stuck(input int want_halt, input int exp_pc);
    repeat (20) begin
      @(negedge clk);
      #2;
      chk("stuck_halted", int'(halted), want_halt);
      chk("stuck_fault", int'(fault), 1 - want_halt);
      chk("stuck_i_req", int'(i_req), 0);
      chk("stuck_d_req", int'(d_req), 0);
      chk("stuck_pc", int'(pc), exp_pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; i_ack = 1'b0; d_ack = 1'b0; i_rdata = '0; halt_at = 1000;
    for (int i = 0; i < 64; i++) begin idel[i] = 0; ddel[i] = 0; end

    // Run 1: zero-wait memory, forced branch to 0xFF then wrap to 0x00
    hold_reset();
    #2;
    chk("rst_i_req", int'(i_req), 0);
    chk("rst_pc", int'(pc), RPC);
    chk("rst_flags", int'({halted, fault, reg_we, d_req}), 0);
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
    imem[0] = 8'h05; imem[1] = 8'hF8; imem[255] = 8'h06;
    halt_at = 12;
    run_model(12);
    release_reset();
    drain(400, "run1");
    check_stuck(1, exp_halt_pc);

    // Run 2: random latencies, first fetch and first data access at the timeout boundary
    hold_reset();
    for (int i = 0; i < 64; i++) begin idel[i] = $urandom_range(3, 0); ddel[i] = $urandom_range(4, 0); end
    idel[0] = TO - 1; ddel[0] = TO - 1;
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
    imem[0] = 8'h07;
    halt_at = 30;
    run_model(30);
    release_reset();
    drain(3000, "run2");
    check_stuck(1, exp_halt_pc);

    // Run 3: fetch never acked -> FAULT after TO fetch cycles
    hold_reset();
    for (int i = 0; i < 64; i++) idel[i] = 99;
    halt_at = 1000;
    sb.push_back('{kind: 4, val: RPC, cyc: TO});
    release_reset();
    drain(100, "run3");
    check_stuck(0, RPC);

    // Run 4: asynchronous reset in the middle of a data access
    hold_reset();
    for (int i = 0; i < 64; i++) begin idel[i] = $urandom_range(2, 0); ddel[i] = 3; end
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom) | 8'h01;
    halt_at = 40;
    run_model(40);
    release_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (d_req) break;
    end
    chk("saw_d_req", int'(d_req), 1);
    n_rst = 1'b0;
    #1;
    chk("async_d_req", int'(d_req), 0);
    chk("async_d_we", int'(d_we), 0);
    chk("async_i_req", int'(i_req), 0);
    chk("async_reg_we", int'(reg_we), 0);
    hold_reset();
    for (int i = 0; i < 64; i++) idel[i] = 0;
    halt_at = 5;
    run_model(5);
    release_reset();
    #1;
    chk("rel_pc", int'(pc), RPC);
    chk("rel_i_req", int'(i_req), 1);
`ifdef NAND_CPU_PERF_CNT_EN
    chk("rel_cycle_cnt", int'(cycle_cnt), 0);
    chk("rel_retired_cnt", int'(retired_cnt), 0);
`endif
    drain(200, "run4");
    check_stuck(1, exp_halt_pc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
